// File: rtl/sddr_bank_sched.sv
// Open-page SDRAM bank scheduler: one request in flight,
// per-bank write recovery and periodic auto-refresh.
module sddr_bank_sched #(
    parameter int BANK_BITS       = 3,
    parameter int ROW_BITS        = 13,
    parameter int COL_BITS        = 10,
    parameter int tRCD            = 5,
    parameter int tRP             = 5,
    parameter int tRFC            = 88,
    parameter int tREFI           = 6240,
    parameter int BURST_LENGTH    = 8,
    parameter int casWriteLatency = 5,
    parameter int write_recovery  = 5
) (
    input  logic                  ddr_clock_i,
    input  logic                  ctrl_reset_i,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [BANK_BITS+ROW_BITS+COL_BITS-1:0] req_addr_i,
    output logic                  req_ready_o,
    output logic [3:0]            cmd_o,
    output logic [BANK_BITS-1:0]  ba_o,
    output logic [ROW_BITS-1:0]   addr_o,
    output logic                  col_issue_o,
    output logic                  col_write_o,
    output logic                  row_hit_o,
    output logic                  refresh_busy_o
);

    localparam int NUM_BANKS = 2 ** BANK_BITS;
    localparam int ADDR_W =
        BANK_BITS + ROW_BITS + COL_BITS;
    localparam int WR_LOAD =
        casWriteLatency + BURST_LENGTH / 2
        + write_recovery;
    localparam int WR_W = $clog2(WR_LOAD + 1);
    localparam int REF_W = $clog2(tREFI + 1);
    localparam int CNT_W =
        $clog2(tRCD + tRP + tRFC + BURST_LENGTH + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam logic [ROW_BITS-1:0] A10 =
        ROW_BITS'(1024);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_COL,
        S_REF_PRE,
        S_REF,
        S_WAIT
    } state_t;

    state_t               state;
    state_t               ret;
    logic [CNT_W-1:0]     cnt;
    logic [REF_W-1:0]     ref_cnt;
    logic                 ref_due;
    logic                 rst_q;
    logic [NUM_BANKS-1:0] bank_open;
    logic [NUM_BANKS-1:0] wr_busy;
    logic [ROW_BITS-1:0]  open_row [NUM_BANKS];
    logic [WR_W-1:0]      wr_tmr [NUM_BANKS];
    logic [BANK_BITS-1:0] bank;
    logic [BANK_BITS-1:0] in_bank;
    logic [ROW_BITS-1:0]  row;
    logic [ROW_BITS-1:0]  in_row;
    logic [COL_BITS-1:0]  col;
    logic                 wr;
    logic                 hit;

    assign in_bank = req_addr_i[ADDR_W-1 -: BANK_BITS];
    assign in_row  = req_addr_i[COL_BITS +: ROW_BITS];

    always_comb begin
        wr_busy = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            wr_busy[i] = (wr_tmr[i] != '0);
        end
    end

    always_ff @(posedge ddr_clock_i) begin
        if (ctrl_reset_i) begin
            state          <= S_IDLE;
            ret            <= S_IDLE;
            cnt            <= '0;
            ref_cnt        <= REF_W'(tREFI);
            ref_due        <= 1'b0;
            rst_q          <= 1'b1;
            bank_open      <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                open_row[i] <= '0;
                wr_tmr[i]   <= '0;
            end
            bank           <= '0;
            row            <= '0;
            col            <= '0;
            wr             <= 1'b0;
            hit            <= 1'b0;
            req_ready_o    <= 1'b0;
            cmd_o          <= CMD_NOP;
            ba_o           <= '0;
            addr_o         <= '0;
            col_issue_o    <= 1'b0;
            col_write_o    <= 1'b0;
            row_hit_o      <= 1'b0;
            refresh_busy_o <= 1'b0;
        end else begin
            rst_q       <= 1'b0;
            req_ready_o <= 1'b0;
            cmd_o       <= CMD_NOP;
            ba_o        <= '0;
            addr_o      <= '0;
            col_issue_o <= 1'b0;
            col_write_o <= 1'b0;
            row_hit_o   <= 1'b0;

            if (ref_cnt != '0) begin
                ref_cnt <= ref_cnt - 1'b1;
            end else begin
                ref_due <= 1'b1;
            end

            for (int i = 0; i < NUM_BANKS; i++) begin
                if (wr_busy[i]) begin
                    wr_tmr[i] <= wr_tmr[i] - 1'b1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (ref_due) begin
                        state <= S_REF_PRE;
                    end else if (req_valid_i
                                 && req_ready_o) begin
                        bank <= in_bank;
                        row  <= in_row;
                        col  <= req_addr_i[COL_BITS-1:0];
                        wr   <= req_write_i;
                        if (bank_open[in_bank]
                            && open_row[in_bank] == in_row)
                        begin
                            hit   <= 1'b1;
                            state <= S_COL;
                        end else if (bank_open[in_bank]) begin
                            hit   <= 1'b0;
                            state <= S_PRE;
                        end else begin
                            hit   <= 1'b0;
                            state <= S_ACT;
                        end
                    end else begin
                        req_ready_o <= !rst_q
                                       && ref_cnt != '0;
                    end
                end
                S_PRE: begin
                    // hold off until this bank's write
                    // data has been absorbed
                    if (!wr_busy[bank]) begin
                        cmd_o           <= CMD_PRE;
                        ba_o            <= bank;
                        bank_open[bank] <= 1'b0;
                        cnt             <= CNT_W'(tRP);
                        ret             <= S_ACT;
                        state           <= S_WAIT;
                    end
                end
                S_ACT: begin
                    cmd_o           <= CMD_ACT;
                    ba_o            <= bank;
                    addr_o          <= row;
                    bank_open[bank] <= 1'b1;
                    open_row[bank]  <= row;
                    cnt             <= CNT_W'(tRCD);
                    ret             <= S_COL;
                    state           <= S_WAIT;
                end
                S_COL: begin
                    cmd_o       <= wr ? CMD_WR : CMD_RD;
                    ba_o        <= bank;
                    addr_o      <= ROW_BITS'(col);
                    col_issue_o <= 1'b1;
                    col_write_o <= wr;
                    row_hit_o   <= hit;
                    if (wr) begin
                        wr_tmr[bank] <= WR_W'(WR_LOAD);
                    end
                    cnt   <= CNT_W'(BURST_LENGTH / 2);
                    ret   <= S_IDLE;
                    state <= S_WAIT;
                end
                S_REF_PRE: begin
                    if (wr_busy == '0) begin
                        if (bank_open != '0) begin
                            cmd_o     <= CMD_PRE;
                            addr_o    <= A10;
                            bank_open <= '0;
                            cnt       <= CNT_W'(tRP);
                            ret       <= S_REF;
                            state     <= S_WAIT;
                        end else begin
                            state <= S_REF;
                        end
                    end
                end
                S_REF: begin
                    cmd_o          <= CMD_REF;
                    ref_cnt        <= REF_W'(tREFI);
                    ref_due        <= 1'b0;
                    refresh_busy_o <= 1'b1;
                    cnt            <= CNT_W'(tRFC);
                    ret            <= S_IDLE;
                    state          <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        cnt            <= '0;
                        state          <= ret;
                        refresh_busy_o <= 1'b0;
                        if (ret == S_IDLE) begin
                            req_ready_o <= ref_cnt != '0
                                           && !ref_due;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sddr_bank_sched.sv
// Directed bench for sddr_bank_sched: vector table for
// request sequences, hand sequences for refresh and reset.
module tb_sddr_bank_sched;

    localparam int BB    = 3;
    localparam int RB    = 13;
    localparam int CB    = 10;
    localparam int TREFI = 6240;
    localparam int TRFC  = 88;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              write;
    logic [BB+RB+CB-1:0] addr;
    logic              req_ready_o;
    logic [3:0]        cmd_o;
    logic [BB-1:0]     ba_o;
    logic [RB-1:0]     addr_o;
    logic              col_issue_o;
    logic              col_write_o;
    logic              row_hit_o;
    logic              refresh_busy_o;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sddr_bank_sched #(
        .BANK_BITS(BB),
        .ROW_BITS(RB),
        .COL_BITS(CB),
        .tREFI(TREFI),
        .tRFC(TRFC)
    ) dut (
        .ddr_clock_i(clk),
        .ctrl_reset_i(rst),
        .req_valid_i(valid),
        .req_write_i(write),
        .req_addr_i(addr),
        .req_ready_o(req_ready_o),
        .cmd_o(cmd_o),
        .ba_o(ba_o),
        .addr_o(addr_o),
        .col_issue_o(col_issue_o),
        .col_write_o(col_write_o),
        .row_hit_o(row_hit_o),
        .refresh_busy_o(refresh_busy_o)
    );

    typedef struct {
        string      nm;
        bit         wr;
        int         bank;
        int         row;
        int         col;
        bit         hit;
        int         n;
        logic [3:0] c0;
        int         t0;
        logic [3:0] c1;
        int         t1;
        logic [3:0] c2;
        int         t2;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(
        input string nm, input bit wr,
        input int b, input int r, input int c,
        input bit h, input int n,
        input logic [3:0] c0, input int t0,
        input logic [3:0] c1, input int t1,
        input logic [3:0] c2, input int t2);
        vec_t v;
        v.nm = nm; v.wr = wr; v.bank = b;
        v.row = r; v.col = c; v.hit = h; v.n = n;
        v.c0 = c0; v.t0 = t0;
        v.c1 = c1; v.t1 = t1;
        v.c2 = c2; v.t2 = t2;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [31:0] quiet();
        return 32'({cmd_o, ba_o, addr_o,
                    col_issue_o, row_hit_o});
    endfunction

    task automatic do_req(input vec_t v);
        logic [3:0]  ec [3];
        int          et [3];
        int          idx;
        bit          acc;
        bit          is_col;
        logic [31:0] ea;
        ec[0] = v.c0; ec[1] = v.c1; ec[2] = v.c2;
        et[0] = v.t0; et[1] = v.t1; et[2] = v.t2;
        idx = 0;
        acc = 1'b0;
        write = v.wr;
        addr = {BB'(v.bank), RB'(v.row), CB'(v.col)};
        valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({v.nm, " accept"}, 32'(acc), 32'd1);
        if (!acc) begin
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        write = ~v.wr;
        addr  = ~addr;
        for (int k = 1; k <= et[v.n-1]; k++) begin
            @(negedge clk);
            if (idx < v.n && k == et[idx]) begin
                is_col = (ec[idx] == RD || ec[idx] == WR);
                if (ec[idx] == PRE) ea = 0;
                else if (ec[idx] == ACT) ea = v.row;
                else ea = v.col;
                chk({v.nm, " cmd"}, 32'(cmd_o),
                    32'(ec[idx]));
                chk({v.nm, " ba"}, 32'(ba_o), v.bank);
                chk({v.nm, " addr"}, 32'(addr_o), ea);
                chk({v.nm, " col_issue"},
                    32'(col_issue_o), 32'(is_col));
                if (is_col) begin
                    chk({v.nm, " col_write"},
                        32'(col_write_o), 32'(v.wr));
                    chk({v.nm, " row_hit"},
                        32'(row_hit_o), 32'(v.hit));
                end
                idx++;
            end else begin
                chk({v.nm, " quiet"}, quiet(),
                    32'({NOP, 18'd0}));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d, pre_t, pre_a, ref_t;
        int busy_first, busy_n;
        bit rdy_seen, acc;

        vt[0] = mk("rd_closed", 0, 2, 'h1A3, 'h040, 0,
                   2, ACT, 2, RD, 8, NOP, 0);
        vt[1] = mk("rd_hit", 0, 2, 'h1A3, 'h041, 1,
                   1, RD, 2, NOP, 0, NOP, 0);
        vt[2] = mk("wr_conflict", 1, 2, 'h055, 'h3FF, 0,
                   3, PRE, 2, ACT, 8, WR, 14);
        vt[3] = mk("wr_b1", 1, 1, 'h007, 'h010, 0,
                   2, ACT, 2, WR, 8, NOP, 0);
        vt[4] = mk("wr_recovery", 0, 1, 'h008, 'h020, 0,
                   3, PRE, 11, ACT, 17, RD, 23);
        vt[5] = mk("open_b0", 0, 0, 'h0F0, 'h001, 0,
                   2, ACT, 2, RD, 8, NOP, 0);
        vt[6] = mk("open_b3", 1, 3, 'h1FFF, 'h3FF, 0,
                   2, ACT, 2, WR, 8, NOP, 0);
        vt[7] = mk("after_ref", 0, 0, 'h123, 'h007, 0,
                   2, ACT, 2, RD, 8, NOP, 0);
        vt[8] = mk("after_rst_b5", 0, 5, 'h0AA, 'h003, 0,
                   2, ACT, 2, RD, 8, NOP, 0);
        vt[9] = mk("after_rst_b0", 0, 0, 'h123, 'h000, 0,
                   2, ACT, 2, RD, 8, NOP, 0);

        rst   = 1'b1;
        valid = 1'b1;
        write = 1'b0;
        addr  = '0;
        @(negedge clk);
        chk("reset outs a",
            32'({cmd_o, ba_o, addr_o, col_issue_o,
                 col_write_o, row_hit_o,
                 refresh_busy_o, req_ready_o}),
            32'({NOP, 21'd0}));
        @(negedge clk);
        chk("reset outs b",
            32'({cmd_o, ba_o, addr_o, col_issue_o,
                 col_write_o, row_hit_o,
                 refresh_busy_o, req_ready_o}),
            32'({NOP, 21'd0}));
        r0    = cyc;
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("ready after reset", 32'(req_ready_o), 0);
        chk("cmd after reset", 32'(cmd_o), 32'(NOP));
        @(negedge clk);
        chk("ready idle", 32'(req_ready_o), 1);

        for (int i = 0; i < 7; i++) do_req(vt[i]);

        // refresh fires with banks open and a request waiting
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) break;
            @(negedge clk);
        end
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (!req_ready_o) break;
        end
        d = cyc;
        chk("refresh due cycle", d - r0, TREFI + 1);
        write = 1'b0;
        addr  = {BB'(0), RB'('h123), CB'('h007)};
        valid = 1'b1;
        pre_t = -1; pre_a = -1; ref_t = -1;
        busy_first = -1; busy_n = 0; rdy_seen = 0;
        for (int k = 1; k <= 95; k++) begin
            @(negedge clk);
            if (cmd_o == PRE && pre_t < 0) begin
                pre_t = k;
                pre_a = int'(addr_o);
            end
            if (cmd_o == REF && ref_t < 0) ref_t = k;
            if (refresh_busy_o) begin
                if (busy_first < 0) busy_first = k;
                busy_n++;
            end
            if (req_ready_o) rdy_seen = 1'b1;
        end
        chk("ref pre_all time", pre_t, 2);
        chk("ref pre_all addr", pre_a, 'h400);
        chk("ref cmd time", ref_t, 8);
        chk("ref busy start", busy_first, 8);
        chk("ref busy length", busy_n, TRFC);
        chk("ref ready held low", 32'(rdy_seen), 0);
        @(negedge clk);
        chk("ref done busy", 32'(refresh_busy_o), 0);
        chk("ref done ready", 32'(req_ready_o), 1);
        do_req(vt[7]);

        // reset lands one cycle after an ACT
        write = 1'b0;
        addr  = {BB'(5), RB'('h0AA), CB'('h003)};
        valid = 1'b1;
        acc   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid accept", 32'(acc), 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid act", 32'({cmd_o, ba_o, addr_o}),
            32'({ACT, 3'd5, 13'h0AA}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid outs",
            32'({cmd_o, ba_o, addr_o, col_issue_o,
                 col_write_o, row_hit_o,
                 refresh_busy_o, req_ready_o}),
            32'({NOP, 21'd0}));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rst_mid quiet", quiet(),
                32'({NOP, 18'd0}));
        end
        do_req(vt[8]);
        do_req(vt[9]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sddr_bank_sched.md
SDDR_BANK_SCHED -- requirements
Module: sddr_bank_sched

Interface
REQ-001 Parameter BANK_BITS, default 3: bank address width; NUM_BANKS = 2**BANK_BITS.
REQ-002 Parameter ROW_BITS, default 13: row address width; legal only if ROW_BITS >= 11.
REQ-003 Parameter COL_BITS, default 10: column address width; legal only if COL_BITS <= 10.
REQ-004 Parameters tRCD=5, tRP=5, tRFC=88, tREFI=6240, BURST_LENGTH=8, casWriteLatency=5, write_recovery=5: timings in ddr_clock_i cycles.
REQ-005 ddr_clock_i  in  1  sole clock; all logic on its rising edge.
REQ-006 ctrl_reset_i  in  1  reset; synchronous, active-high.
REQ-007 req_valid_i  in  1  request present.
REQ-008 req_write_i  in  1  1 = write, 0 = read.
REQ-009 req_addr_i  in  BANK_BITS+ROW_BITS+COL_BITS  {bank, row, col}, bank in the MSBs.
REQ-010 req_ready_o  out  1  request accepted this cycle when high with req_valid_i.
REQ-011 cmd_o  out  4  {CS#,RAS#,CAS#,WE#}: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001.
REQ-012 ba_o  out  BANK_BITS  bank for the current command.
REQ-013 addr_o  out  ROW_BITS  row (ACT), column with A10=0 (RD/WR), A10=1 for precharge-all.
REQ-014 col_issue_o  out  1  one-cycle pulse on each RD/WR; col_write_o  out  1  qualifies it.
REQ-015 row_hit_o  out  1  one-cycle pulse with col_issue_o when no PRE/ACT was needed.
REQ-016 refresh_busy_o  out  1  high from refresh start until tRFC expires.

Function
REQ-017 Open-page policy: per-bank open flag and open-row register; a row stays open after RD/WR.
REQ-018 One outstanding request; req_ready_o high only in IDLE with no refresh due.
REQ-019 All outputs registered; cmd_o = NOP, ba_o = 0, addr_o = 0 on every cycle with no command.
REQ-020 States: IDLE, PRE, ACT, COL, REF_PRE, REF, WAIT; WAIT counts a loaded value down to 0, then enters its stored return state.
REQ-021 IDLE on accept: bank open with matching row -> COL; bank open with other row -> PRE; bank closed -> ACT.
REQ-022 PRE: issue PRE (A10=0) to the request bank, clear its open flag, WAIT tRP -> ACT.
REQ-023 ACT: issue ACT with the request row, set open flag and row, WAIT tRCD -> COL.
REQ-024 COL: issue RD/WR, col field zero-extended into addr_o[9:0], A10=0; next command no earlier than BURST_LENGTH/2 cycles later; -> IDLE.
REQ-025 Row hit: the accepting cycle is cycle 0; RD/WR appears on cmd_o at cycle 2.
REQ-026 Per-bank write-recovery timer loaded with casWriteLatency+BURST_LENGTH/2+write_recovery on WR; PRE to that bank (or REF_PRE) stalls until it reaches 0.
REQ-027 Refresh counter: loaded with tREFI, decrements every cycle, saturates at 0; 0 sets refresh_due.
REQ-028 refresh_due is serviced only from IDLE, and takes priority over a same-cycle req_valid_i.
REQ-029 REF_PRE: if any bank is open, issue PRE with A10=1, clear all open flags, WAIT tRP; otherwise skip.
REQ-030 REF: issue REF, reload the refresh counter with tREFI, clear refresh_due, WAIT tRFC -> IDLE.
REQ-031 refresh_due arriving mid-request does not abort the request; refresh follows its completion.
REQ-032 Request fields are latched on accept; input changes afterwards have no effect.

Reset
REQ-033 ctrl_reset_i clears state to IDLE and all open flags, timers and WAIT count to 0; it loads the refresh counter with tREFI.
REQ-034 During reset and the cycle after: cmd_o = 0111, ba_o = 0, addr_o = 0, all pulses 0, req_ready_o = 0.
REQ-035 Reset mid-sequence abandons the request and issues no further command.

Verification
REQ-036 Closed bank 2, read row 0x1A3 col 0x40 -> ACT ba=2 addr=0x1A3; RD ba=2 addr=0x040 after tRCD+1 cycles; row_hit_o=0.
REQ-037 Repeat the read to bank 2 row 0x1A3 -> RD only, issued 2 cycles after accept; row_hit_o=1.
REQ-038 Bank 2 row 0x1A3 open, write row 0x055 -> PRE ba=2 addr=0; ACT 0x055; WR, spaced by tRP+1 and tRCD+1 cycles.
REQ-039 WR to bank 1, then immediately a miss to bank 1 -> PRE delayed until the 15-cycle recovery expires.
REQ-040 Refresh counter at 0 with banks 0 and 3 open and req_valid_i high -> PRE addr=0x400; REF after tRP+1 cycles; refresh_busy_o high for tRFC cycles; request accepted afterwards as an ACT.
REQ-041 Assert ctrl_reset_i one cycle after ACT -> no RD/WR issued; all banks closed; next request starts with ACT.
